img_row_loader: RTL

- Upstream feeder for the image coprocessor's boot port.
- Accepts a stream of 32-bit words from the CPU/bootloader side over a valid/ready handshake and packs each group of 96 words into one 3072-bit image row (256 pixels × 12 bits).
- Drives `we_boot`, `wdata_boot`, `waddr_boot` and `bootloading` of the coprocessor's image buffer, one row-write per completed row, at consecutive row addresses from a programmable base.

---
 rtl/img_row_loader.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/img_row_loader.sv
// Packs a stream of WORD_W-bit words into ROW_W-bit image rows and writes each
// completed row into the coprocessor image buffer through its boot port.
module img_row_loader #(
    parameter int WORD_W = 32,
    parameter int ROW_W  = 3072,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_rows,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              we_boot,
    output logic [ROW_W-1:0]  wdata_boot,
    output logic [ADDR_W-1:0] waddr_boot,
    output logic              bootloading,
    output logic              done
);

    localparam int WPR     = ROW_W / WORD_W;
    localparam int WCNT_W  = $clog2(WPR);
    localparam int NROWS_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_WRITE,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ROW_W-1:0]    row_sr_q, row_sr_d;
    logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [ADDR_W-1:0]   row_cnt_q, row_cnt_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [NROWS_W-1:0]  num_rows_q, num_rows_d;

    logic                in_ready_q, in_ready_d;
    logic                we_boot_q, we_boot_d;
    logic [ROW_W-1:0]    wdata_q, wdata_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic                bootloading_q, bootloading_d;
    logic                done_q, done_d;

    logic                xfer;
    logic                last_word;
    logic                last_row;
    logic [ADDR_W-1:0]   row_addr;

    // in_ready_q mirrors state_q==S_FILL, so this is the handshake as seen outside.
    assign xfer      = (state_q == S_FILL) && in_valid;
    assign last_word = (word_cnt_q == WCNT_W'(WPR - 1));
    assign last_row  = ({1'b0, row_cnt_q} == (num_rows_q - NROWS_W'(1)));
    assign row_addr  = base_q + row_cnt_q;

    // Next-state and counter logic.
    always_comb begin
        // NOTE: every _d takes its current value first, so no branch can leave one unassigned and infer a latch.
        state_d    = state_q;
        row_sr_d   = row_sr_q;
        word_cnt_d = word_cnt_q;
        row_cnt_d  = row_cnt_q;
        base_d     = base_q;
        num_rows_d = num_rows_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_rows != '0) begin
                        base_d     = base_addr;
                        num_rows_d = num_rows;
                        row_cnt_d  = '0;
                        word_cnt_d = '0;
                        row_sr_d   = '0;
                        state_d    = S_FILL;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end

            S_FILL: begin
                if (abort) begin
                    row_cnt_d  = '0;
                    word_cnt_d = '0;
                    state_d    = S_IDLE;
                end else if (xfer) begin
                    row_sr_d = {in_data, row_sr_q[ROW_W-1:WORD_W]};
                    if (last_word) begin
                        word_cnt_d = '0;
                        state_d    = S_WRITE;
                    end else begin
                        word_cnt_d = word_cnt_q + WCNT_W'(1);
                    end
                end
            end

            S_WRITE: begin
                if (abort) begin
                    row_cnt_d  = '0;
                    word_cnt_d = '0;
                    state_d    = S_IDLE;
                end else if (last_row) begin
                    state_d = S_DONE;
                end else begin
                    row_cnt_d = row_cnt_q + ADDR_W'(1);
                    state_d   = S_FILL;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin
        in_ready_d    = (state_d == S_FILL);
        bootloading_d = (state_d == S_FILL) || (state_d == S_WRITE);
        we_boot_d     = (state_d == S_WRITE);
        done_d        = (state_d == S_DONE);
        wdata_d       = wdata_q;
        waddr_d       = waddr_q;
        if (state_d == S_WRITE && state_q == S_FILL) begin
            wdata_d = row_sr_d;
            waddr_d = row_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            // NOTE: the row register is ordinary flops rather than a RAM, so it takes the reset clear like any other state.
            row_sr_q      <= '0;
            word_cnt_q    <= '0;
            row_cnt_q     <= '0;
            base_q        <= '0;
            num_rows_q    <= '0;
            in_ready_q    <= 1'b0;
            we_boot_q     <= 1'b0;
            wdata_q       <= '0;
            waddr_q       <= '0;
            bootloading_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register load from pre-edge values.
            state_q       <= state_d;
            row_sr_q      <= row_sr_d;
            word_cnt_q    <= word_cnt_d;
            row_cnt_q     <= row_cnt_d;
            base_q        <= base_d;
            num_rows_q    <= num_rows_d;
            in_ready_q    <= in_ready_d;
            we_boot_q     <= we_boot_d;
            wdata_q       <= wdata_d;
            waddr_q       <= waddr_d;
            bootloading_q <= bootloading_d;
            done_q        <= done_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign we_boot     = we_boot_q;
    assign wdata_boot  = wdata_q;
    assign waddr_boot  = waddr_q;
    assign bootloading = bootloading_q;
    assign done        = done_q;

endmodule
